pmp_access_gate: RTL

// - Sequential gate between the LSU/fetch request path and the memory bus. Registers one access and presents it to
//   the combinational PMP checker (chk_* ports), then acts on the checker's 2-bit permission result.
// - On permission 2'b11 the access is forwarded to memory. Otherwise no bus access is issued and an access-fault

---
 rtl/pmp_access_gate.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pmp_access_gate.sv
// Sequential PMP gate: registers one access, consults the PMP checker, then forwards or faults.
// Optional saturating fault counter enabled by defining PMP_FAULT_CNT_EN.
module pmp_access_gate #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [1:0]       req_size_i,
    input  logic [1:0]       req_oper_i,
    input  logic [1:0]       req_priv_i,
    input  logic [31:0]      req_wdata_i,
    output logic [31:0]      chk_addr_o,
    output logic [1:0]       chk_size_o,
    output logic [1:0]       chk_oper_o,
    output logic [1:0]       chk_priv_o,
    input  logic [1:0]       chk_perm_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [1:0]       mem_size_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_fault_o,
    output logic [3:0]       rsp_cause_o,
    output logic [31:0]      rsp_tval_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCheck   = 3'd1;
    localparam logic [2:0] StMemReq  = 3'd2;
    localparam logic [2:0] StMemWait = 3'd3;
    localparam logic [2:0] StResp    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  oper_q, oper_d;
    logic [1:0]  priv_q, priv_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] tval_q, tval_d;

    logic [3:0]  chk_cause;
    logic        chk_fault;

    // Illegal size/oper faults by operation; otherwise the checker verdict picks the cause.
    always_comb begin
        chk_cause = 4'd0;
        if (size_q == 2'b11 || oper_q == 2'b11) begin
            case (oper_q)
                2'b10:   chk_cause = 4'd1;
                2'b01:   chk_cause = 4'd7;
                default: chk_cause = 4'd5;
            endcase
        end else begin
            case (chk_perm_i)
                2'b00:   chk_cause = 4'd5;
                2'b01:   chk_cause = 4'd7;
                2'b10:   chk_cause = 4'd1;
                default: chk_cause = 4'd0;
            endcase
        end
    end
    assign chk_fault = (chk_cause != 4'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        oper_d  = oper_q;
        priv_d  = priv_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    oper_d  = req_oper_i;
                    priv_d  = req_priv_i;
                    wdata_d = req_wdata_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (chk_fault) begin
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                    cause_d = chk_cause;
                    tval_d  = addr_q;
                    state_d = StResp;
                end else begin
                    state_d = StMemReq;
                end
            end
            StMemReq: begin
                if (mem_ready_i) state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_rvalid_i) begin
                    rdata_d = (oper_q == 2'b01) ? 32'd0 : mem_rdata_i;
                    fault_d = 1'b0;
                    cause_d = 4'd0;
                    tval_d  = 32'd0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            oper_q  <= 2'd0;
            priv_q  <= 2'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
            cause_q <= 4'd0;
            tval_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            oper_q  <= oper_d;
            priv_q  <= priv_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign chk_addr_o  = addr_q;
    assign chk_size_o  = size_q;
    assign chk_oper_o  = oper_q;
    assign chk_priv_o  = priv_q;
    assign mem_valid_o = (state_q == StMemReq);
    assign mem_addr_o  = addr_q;
    assign mem_size_o  = size_q;
    assign mem_we_o    = (oper_q == 2'b01);
    assign mem_wdata_o = wdata_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_fault_o = fault_q;
    assign rsp_cause_o = cause_q;
    assign rsp_tval_o  = tval_q;

`ifdef PMP_FAULT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StCheck && chk_fault && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign fault_cnt_o = cnt_q;
`else
    assign fault_cnt_o = '0;
`endif

endmodule
